regfile_dump_reader: RTL

Sequential read-side master for the 32×32 register file. On a start request it freezes architectural writeback, walks every register through one register-file read port in index order, and streams each value out on a valid/ready interface for debug/trace capture. It sits beside the core datapath. It borrows one read port, Rs1-side, through a mux controlled by `busy`, and its `freeze` output gates the core's `RegWrite` while a snapshot is taken.

---
 rtl/regdump_pkg.sv | 31 +++
 rtl/regdump_out_stage.sv | 54 +++++
 rtl/regfile_dump_reader.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/regdump_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : regdump_pkg                                                    |
// | Brief   : Shared constants and FSM encoding for the register-file dump   |
// |           reader.                                                        |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package regdump_pkg;

  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;
  localparam int REG_AW   = 5;
  localparam int IDX_W    = 6;

  localparam logic [IDX_W-1:0] CKSUM_IDX = 6'd32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FREEZE = 3'd1,
    READ   = 3'd2,
    SEND   = 3'd3,
    CKSUM  = 3'd4,
    DONE   = 3'd5
  } state_t;

  function automatic logic [IDX_W-1:0] beat_idx(input logic [REG_AW-1:0] idx);
    return {1'b0, idx};
  endfunction

endpackage
`default_nettype wire

// File: rtl/regdump_out_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : regdump_out_stage                                              |
// | Brief   : Registered valid/ready output beat holding data, index, last.  |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module regdump_out_stage #(
  parameter int XLEN  = 32,
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [XLEN-1:0]  i_data,
  input  logic [IDX_W-1:0] i_idx,
  input  logic             i_last,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [XLEN-1:0]  o_data,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_last,
  output logic             o_fire
);

  logic             r_valid;
  logic [XLEN-1:0]  r_data;
  logic [IDX_W-1:0] r_idx;
  logic             r_last;

  // A load always wins over a handshake so back-to-back beats keep valid high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_idx   <= '0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_idx   <= i_idx;
      r_last  <= i_last;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_idx   = r_idx;
  assign o_last  = r_last;
  assign o_fire  = r_valid & i_ready;

endmodule
`default_nettype wire

// File: rtl/regfile_dump_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : regfile_dump_reader                                            |
// | Brief   : Freezes writeback, walks the register file through one read    |
// |           port and streams every value out on valid/ready. Define        |
// |           REGDUMP_CHECKSUM_EN to append an XOR checksum beat.            |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module regfile_dump_reader #(
  parameter int XLEN     = regdump_pkg::XLEN,
  parameter int NUM_REGS = regdump_pkg::NUM_REGS
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            busy,
  output logic            freeze,
  output logic            done,
  output logic [4:0]      rf_raddr,
  input  logic [XLEN-1:0] rf_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [5:0]      out_idx,
  output logic            out_last
);

  import regdump_pkg::*;

  localparam logic [REG_AW-1:0] c_LAST_IDX = REG_AW'(NUM_REGS - 1);

  state_t            r_state;
  logic [REG_AW-1:0] r_idx;
  logic              r_busy;
  logic              r_freeze;
  logic              r_done;

  logic              w_fire;
  logic              w_last_idx;
  logic              w_load;
  logic [XLEN-1:0]   w_load_data;
  logic [IDX_W-1:0]  w_load_idx;
  logic              w_load_last;

  assign w_last_idx = (r_idx == c_LAST_IDX);

`ifdef REGDUMP_CHECKSUM_EN
  logic [XLEN-1:0] r_cksum;
  logic            w_cksum_load;

  // Checksum beat is loaded on the same edge the last data beat is accepted.
  assign w_cksum_load = (r_state == SEND) && w_fire && w_last_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cksum <= '0;
    end else if (r_state == IDLE && start) begin
      r_cksum <= '0;
    end else if (r_state == READ) begin
      r_cksum <= r_cksum ^ rf_rdata;
    end
  end

  assign w_load      = (r_state == READ) | w_cksum_load;
  assign w_load_data = w_cksum_load ? r_cksum : rf_rdata;
  assign w_load_idx  = w_cksum_load ? CKSUM_IDX : beat_idx(r_idx);
  assign w_load_last = w_cksum_load;
`else
  assign w_load      = (r_state == READ);
  assign w_load_data = rf_rdata;
  assign w_load_idx  = beat_idx(r_idx);
  assign w_load_last = w_last_idx;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_busy   <= 1'b0;
      r_freeze <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state  <= FREEZE;
            r_idx    <= '0;
            r_busy   <= 1'b1;
            r_freeze <= 1'b1;
          end
        end
        // One dead cycle lets a writeback already in flight retire.
        FREEZE: r_state <= READ;
        READ:   r_state <= SEND;
        SEND: begin
          if (w_fire) begin
            if (w_last_idx) begin
`ifdef REGDUMP_CHECKSUM_EN
              r_state  <= CKSUM;
`else
              r_state  <= DONE;
              r_freeze <= 1'b0;
              r_done   <= 1'b1;
`endif
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= READ;
            end
          end
        end
`ifdef REGDUMP_CHECKSUM_EN
        CKSUM: begin
          if (w_fire) begin
            r_state  <= DONE;
            r_freeze <= 1'b0;
            r_done   <= 1'b1;
          end
        end
`endif
        DONE: begin
          r_state <= IDLE;
          r_idx   <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state  <= IDLE;
          r_idx    <= '0;
          r_busy   <= 1'b0;
          r_freeze <= 1'b0;
          r_done   <= 1'b0;
        end
      endcase
    end
  end

  regdump_out_stage #(
    .XLEN  (XLEN),
    .IDX_W (IDX_W)
  ) u_out_stage (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_data  (w_load_data),
    .i_idx   (w_load_idx),
    .i_last  (w_load_last),
    .i_ready (out_ready),
    .o_valid (out_valid),
    .o_data  (out_data),
    .o_idx   (out_idx),
    .o_last  (out_last),
    .o_fire  (w_fire)
  );

  assign busy     = r_busy;
  assign freeze   = r_freeze;
  assign done     = r_done;
  assign rf_raddr = r_idx;

endmodule
`default_nettype wire
